fc_sequencer_2: RTL and testbench

Top-level sequencer for the second fully-connected layer. It steps the layer through output-neuron groups (PO neurons per group), and within each group it steps through INNEURON multiply-accumulate cycles followed by a fixed 6-cycle drain/writeback window. It generates the input-neuron and weight read addresses, the accumulator load strobe, and the `count_sload`/`count_out`/`enable` controls consumed by the FC result writeback stage. One `start` pulse runs the whole layer and ends with a one-cycle `done`.

---
 rtl/fc_sequencer_2_if.sv | 27 ++
 rtl/fc_sequencer_2.sv | 116 +++++++++++
 tb/tb_fc_sequencer_2.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fc_sequencer_2_if.sv
// Control bus between the FC layer-2 sequencer and its requester / writeback consumers.
interface fc_sequencer_2_if #(
  parameter int FC_COUNT_SLOAD_BITWIDTH      = 3,
  parameter int FC_COUNT_OUT_NEURON_BITWIDTH = 3,
  parameter int FC_INNEURON_ADDR_WIDTH       = 6,
  parameter int FC_WEIGHT_ADDR_WIDTH         = 8
);
   logic                                    start;
   logic                                    abort;
   logic                                    enable;
   logic                                    mac_sload;
   logic [FC_INNEURON_ADDR_WIDTH-1:0]       inneuron_addr;
   logic [FC_WEIGHT_ADDR_WIDTH-1:0]         weight_addr;
   logic [FC_COUNT_SLOAD_BITWIDTH-1:0]      count_sload;
   logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] count_out;
   logic                                    busy;
   logic                                    done;

   modport master (
      output start, abort,
      input  enable, mac_sload, inneuron_addr, weight_addr, count_sload, count_out, busy, done
   );
   modport slave (
      input  start, abort,
      output enable, mac_sload, inneuron_addr, weight_addr, count_sload, count_out, busy, done
   );
endinterface

// File: rtl/fc_sequencer_2.sv
// Sequencer for FC layer 2: per output group, INNEURON MAC cycles then a 6-cycle drain/writeback window.
module fc_sequencer_2 #(
   parameter int INNEURON                     = 64,
   parameter int OUTNEURON                    = 16,
   parameter int PO                           = 4,
   parameter int FC_COUNT_SLOAD_BITWIDTH      = 3,
   parameter int FC_COUNT_OUT_NEURON_BITWIDTH = 3,
   parameter int FC_INNEURON_ADDR_WIDTH       = 6,
   parameter int FC_WEIGHT_ADDR_WIDTH         = 8
) (
   input  logic              clock,
   input  logic              reset,
   fc_sequencer_2_if.slave   bus
);
   localparam int IW = FC_INNEURON_ADDR_WIDTH;
   localparam int WW = FC_WEIGHT_ADDR_WIDTH;
   localparam int SW = FC_COUNT_SLOAD_BITWIDTH;
   localparam int CW = FC_COUNT_OUT_NEURON_BITWIDTH;
   localparam int G  = OUTNEURON / PO;

   localparam logic [IW-1:0] K_LAST  = IW'(INNEURON - 1);
   localparam logic [SW-1:0] CS_LAST = SW'(6);
   localparam logic [CW-1:0] G_LAST  = CW'(G);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_DONE} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] k;
   logic [WW-1:0] w;
   logic [SW-1:0] cs;
   logic [CW-1:0] co;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = S_MAC;
         S_MAC:   if (k == K_LAST) state_nx = S_DRAIN;
         S_DRAIN: if (cs == CS_LAST) state_nx = (co == G_LAST) ? S_DONE : S_MAC;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (bus.abort) state_nx = S_IDLE;
   end

   // Counters follow the next state so every output decodes straight from registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k  <= '0;
         w  <= '0;
         cs <= '0;
         co <= '0;
      end else begin
         case (state_nx)
            S_MAC: begin
               cs <= '0;
               k  <= (state == S_MAC) ? k + 1'b1 : '0;
               if (state == S_IDLE) begin
                  w  <= '0;
                  co <= CW'(1);
               end else begin
                  w <= w + 1'b1;
                  if (state == S_DRAIN) co <= co + 1'b1;
               end
            end
            S_DRAIN: cs <= (state == S_MAC) ? SW'(1) : cs + 1'b1;
            S_IDLE: begin
               k  <= '0;
               w  <= '0;
               cs <= '0;
               co <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.enable        = 1'b0;
      bus.mac_sload     = 1'b0;
      bus.inneuron_addr = '0;
      bus.weight_addr   = '0;
      bus.count_sload   = '0;
      bus.count_out     = '0;
      bus.busy          = 1'b0;
      bus.done          = 1'b0;
      case (state)
         S_MAC: begin
            bus.enable        = 1'b1;
            bus.busy          = 1'b1;
            bus.mac_sload     = (k == '0);
            bus.inneuron_addr = k;
            bus.weight_addr   = w;
            bus.count_out     = co;
         end
         S_DRAIN: begin
            bus.enable        = 1'b1;
            bus.busy          = 1'b1;
            bus.inneuron_addr = k;
            bus.weight_addr   = w;
            bus.count_sload   = cs;
            bus.count_out     = co;
         end
         S_DONE: begin
            bus.busy      = 1'b1;
            bus.done      = 1'b1;
            bus.count_out = co;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_fc_sequencer_2.sv
// Directed bench: default-size sequencer plus an INNEURON=1, G=1 corner instance.
module tb_fc_sequencer_2;
   logic clock = 1'b0;
   logic rst_a, rst_b;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   fc_sequencer_2_if #(.FC_COUNT_SLOAD_BITWIDTH(3), .FC_COUNT_OUT_NEURON_BITWIDTH(3),
                       .FC_INNEURON_ADDR_WIDTH(6), .FC_WEIGHT_ADDR_WIDTH(8)) ia ();
   fc_sequencer_2_if #(.FC_COUNT_SLOAD_BITWIDTH(3), .FC_COUNT_OUT_NEURON_BITWIDTH(3),
                       .FC_INNEURON_ADDR_WIDTH(1), .FC_WEIGHT_ADDR_WIDTH(1)) ib ();

   fc_sequencer_2 #(.INNEURON(64), .OUTNEURON(16), .PO(4), .FC_COUNT_SLOAD_BITWIDTH(3),
                    .FC_COUNT_OUT_NEURON_BITWIDTH(3), .FC_INNEURON_ADDR_WIDTH(6),
                    .FC_WEIGHT_ADDR_WIDTH(8))
      dut_a (.clock(clock), .reset(rst_a), .bus(ia.slave));

   fc_sequencer_2 #(.INNEURON(1), .OUTNEURON(4), .PO(4), .FC_COUNT_SLOAD_BITWIDTH(3),
                    .FC_COUNT_OUT_NEURON_BITWIDTH(3), .FC_INNEURON_ADDR_WIDTH(1),
                    .FC_WEIGHT_ADDR_WIDTH(1))
      dut_b (.clock(clock), .reset(rst_b), .bus(ib.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pack(bit dn, bit bz, bit en, bit sl, int co, int cs, int w, int k);
      logic [3:0] c4; logic [2:0] s3; logic [9:0] w10; logic [7:0] k8;
      c4 = co[3:0]; s3 = cs[2:0]; w10 = w[9:0]; k8 = k[7:0];
      return {3'b0, dn, bz, en, sl, c4, s3, w10, k8};
   endfunction

   // Expected outputs c cycles after the start sample, from the timing table.
   function automatic logic [31:0] exp_at(int c, int n, int g);
      int p, gi;
      if (c >= 1 && c <= g * (n + 6)) begin
         gi = (c - 1) / (n + 6) + 1;
         p  = (c - 1) % (n + 6);
         if (p < n) return pack(0, 1, 1, p == 0, gi, 0, (gi - 1) * n + p, p);
         return pack(0, 1, 1, 0, gi, p - n + 1, (gi - 1) * n + n - 1, n - 1);
      end
      if (c == g * (n + 6) + 1) return pack(1, 1, 0, 0, g, 0, 0, 0);
      return '0;
   endfunction

   function automatic logic [31:0] got_a();
      return pack(ia.done, ia.busy, ia.enable, ia.mac_sload, int'(ia.count_out),
                  int'(ia.count_sload), int'(ia.weight_addr), int'(ia.inneuron_addr));
   endfunction

   function automatic logic [31:0] got_b();
      return pack(ib.done, ib.busy, ib.enable, ib.mac_sload, int'(ib.count_out),
                  int'(ib.count_sload), int'(ib.weight_addr), int'(ib.inneuron_addr));
   endfunction

   initial begin
      int done_cnt, done_cyc, sload_hits;
      ia.start = 0; ia.abort = 0; ib.start = 0; ib.abort = 0;
      rst_a = 1; rst_b = 1;
      tick(); tick();
      chk("reset_a", got_a(), 32'h0);
      chk("reset_b", got_b(), 32'h0);
      rst_a = 0; rst_b = 0;
      tick();

      // Full run; extra starts at 10 and 280 must be ignored, 282 starts a new run.
      ia.start = 1;
      tick();
      done_cnt = 0; done_cyc = -1; sload_hits = 0;
      for (int c = 1; c <= 282; c++) begin
         ia.start = (c == 10 || c == 280 || c == 282);
         chk($sformatf("run_c%0d", c), got_a(), exp_at(c, 64, 4));
         if (ia.done) begin done_cnt++; done_cyc = c; end
         if (ia.mac_sload && (c == 1 || c == 71 || c == 141 || c == 211)) sload_hits++;
         if (c == 274) chk("waddr_274", 32'(ia.weight_addr), 32'd255);
         if (c == 68)  chk("cs_68", 32'(ia.count_sload), 32'd4);
         if (c == 282) chk("busy_282", 32'(ia.busy), 32'd0);
         tick();
      end
      ia.start = 0;
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'd281);
      chk("sload_hits", 32'(sload_hits), 32'd4);

      // Cycle 283 is cycle 1 of the run started at 282; abort at its cycle 100.
      for (int c = 1; c <= 387; c++) begin
         ia.abort = (c == 100);
         ia.start = (c == 105);
         if (c <= 100)      chk($sformatf("ab_c%0d", c), got_a(), exp_at(c, 64, 4));
         else if (c <= 105) chk($sformatf("ab_idle_c%0d", c), got_a(), 32'h0);
         else               chk($sformatf("re_c%0d", c), got_a(), exp_at(c - 105, 64, 4));
         tick();
      end
      ia.abort = 0; ia.start = 0;

      // start and abort together in IDLE: stay idle; abort alone in IDLE: no effect.
      ia.start = 1; ia.abort = 1;
      tick();
      ia.start = 0; ia.abort = 0;
      chk("start_abort_idle", got_a(), 32'h0);
      ia.abort = 1;
      tick();
      ia.abort = 0;
      chk("abort_idle", got_a(), 32'h0);

      // Async reset between edges at cycle 150.
      ia.start = 1;
      tick();
      ia.start = 0;
      for (int c = 1; c < 150; c++) tick();
      chk("pre_reset_c150", got_a(), exp_at(150, 64, 4));
      #3 rst_a = 1;
      #1 chk("async_reset", got_a(), 32'h0);
      done_cnt = 0;
      for (int c = 0; c < 150; c++) begin
         if (c == 3) rst_a = 0;
         if (ia.done || ia.busy) done_cnt++;
         tick();
      end
      chk("no_done_after_reset", 32'(done_cnt), 32'd0);
      ia.start = 1;
      tick();
      ia.start = 0;
      chk("restart_c1", got_a(), exp_at(1, 64, 4));
      tick();
      chk("restart_c2", got_a(), exp_at(2, 64, 4));
      ia.abort = 1;
      tick();
      ia.abort = 0;

      // Corner instance: INNEURON=1, G=1, done at cycle 8.
      ib.start = 1;
      tick();
      ib.start = 0;
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("g1_c%0d", c), got_b(), exp_at(c, 1, 1));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
